// File: rtl/window_feeder.sv
// Row-cache consumer: keeps the last K feature-map rows in a line buffer and
// streams K x K sliding windows (row-major) to the PE array.
`timescale 1ns/1ps
module window_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int IF_WIDTH    = 34,
    parameter int IF_HEIGHT   = 34,
    parameter int K           = 3,
    parameter int CACHE_WIDTH = DATA_WIDTH * IF_WIDTH,
    parameter int WIN_WIDTH   = DATA_WIDTH * K * K,
    localparam int ROW_W      = (IF_HEIGHT > 1) ? $clog2(IF_HEIGHT) : 1,
    localparam int COL_W      = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   start,
    input  logic                   cache_empty,
    output logic                   read_cache_req,
    input  logic [CACHE_WIDTH-1:0] cache_out,
    output logic [WIN_WIDTH-1:0]   win_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [ROW_W-1:0]       win_row,
    output logic [COL_W-1:0]       win_col,
    output logic                   busy,
    output logic                   frame_done,
    output logic [2:0]             dbg_state_o
);

    localparam int FILL_W = $clog2(K + 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IF_WIDTH - K);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IF_HEIGHT - K);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(K - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FILL_REQ   = 3'd1,
        FILL_WAIT  = 3'd2,
        STREAM     = 3'd3,
        SLIDE_REQ  = 3'd4,
        SLIDE_WAIT = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [CACHE_WIDTH-1:0]  lb_q [K];
    logic [CACHE_WIDTH-1:0]  lb_d [K];
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [WIN_WIDTH-1:0]    win_q, win_d;
    logic                    valid_q, done_q;
    logic                    load_win, pop, xfer;
    logic [CACHE_WIDTH-1:0]  sh;

    // Handshake: a window moves when win_valid & win_ready are both high on an
    // enabled edge; win_data/win_valid never change while the consumer stalls.
    assign pop  = clk_en & ~cache_empty & ((state_q == FILL_REQ) | (state_q == SLIDE_REQ));
    assign xfer = clk_en & valid_q & win_ready;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        fill_d   = fill_q;
        lb_d     = lb_q;
        load_win = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL_REQ;
                    row_d   = '0;
                    col_d   = '0;
                    fill_d  = '0;
                end
            end
            FILL_REQ:  if (pop) state_d = FILL_WAIT;
            SLIDE_REQ: if (pop) state_d = SLIDE_WAIT;
            FILL_WAIT, SLIDE_WAIT: begin
                for (int i = 0; i < K - 1; i++) lb_d[i] = lb_q[i+1];
                lb_d[K-1] = cache_out;
                load_win  = 1'b1;
                if (state_q == SLIDE_WAIT) begin
                    state_d = STREAM;
                end else begin
                    fill_d  = fill_q + FILL_W'(1);
                    state_d = (fill_q == FILL_LAST) ? STREAM : FILL_REQ;
                end
            end
            STREAM: begin
                if (xfer) begin
                    load_win = 1'b1;
                    if (col_q < COL_LAST) begin
                        col_d = col_q + COL_W'(1);
                    end else if (row_q == ROW_LAST) begin
                        state_d = DONE;
                    end else begin
                        col_d   = '0;
                        row_d   = row_q + ROW_W'(1);
                        state_d = SLIDE_REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window as it will look after this edge; element (0,0) lands in the MSBs.
    always_comb begin
        win_d = '0;
        sh    = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                sh = lb_d[r] >> ((IF_WIDTH - 1 - (int'(col_d) + c)) * DATA_WIDTH);
                win_d[WIN_WIDTH-1-(r*K+c)*DATA_WIDTH -: DATA_WIDTH] = sh[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < K; i++) lb_q[i] <= '0;
            row_q   <= '0;
            col_q   <= '0;
            fill_q  <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            lb_q    <= lb_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fill_q  <= fill_d;
            if (load_win) win_q <= win_d;
            valid_q <= (state_d == STREAM);
            done_q  <= (state_q == DONE);
        end
    end

    assign read_cache_req = pop;
    assign win_data       = win_q;
    assign win_valid      = valid_q;
    assign win_row        = row_q;
    assign win_col        = col_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = done_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder: a 4x4/K=3 instance for the handshake,
// stall, clock-enable and reset cases, and a default 34x34 instance with random pixels.
`timescale 1ns/1ps
module tb_window_feeder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- small instance (4x4, K=3) ----------------
  logic        s_en, s_start, s_empty, s_ready;
  logic        s_req, s_valid, s_busy, s_done;
  logic [31:0] s_cache;
  logic [71:0] s_win;
  logic [1:0]  s_row, s_col;
  logic [2:0]  s_state;

  window_feeder #(.DATA_WIDTH(8), .IF_WIDTH(4), .IF_HEIGHT(4), .K(3)) u_small (
    .clk(clk), .rst_n(rst_n), .clk_en(s_en), .start(s_start),
    .cache_empty(s_empty), .read_cache_req(s_req), .cache_out(s_cache),
    .win_data(s_win), .win_valid(s_valid), .win_ready(s_ready),
    .win_row(s_row), .win_col(s_col), .busy(s_busy), .frame_done(s_done),
    .dbg_state_o(s_state)
  );

  // ---------------- default instance (34x34, K=3) ----------------
  logic         b_en, b_start, b_empty, b_ready;
  logic         b_req, b_valid, b_busy, b_done;
  logic [271:0] b_cache;
  logic [71:0]  b_win;
  logic [5:0]   b_row, b_col;
  logic [2:0]   b_state;

  window_feeder u_big (
    .clk(clk), .rst_n(rst_n), .clk_en(b_en), .start(b_start),
    .cache_empty(b_empty), .read_cache_req(b_req), .cache_out(b_cache),
    .win_data(b_win), .win_valid(b_valid), .win_ready(b_ready),
    .win_row(b_row), .win_col(b_col), .busy(b_busy), .frame_done(b_done),
    .dbg_state_o(b_state)
  );

  // ---------------- upstream FIFO models (read latency 1) ----------------
  logic [31:0]  s_rows [8];
  int           s_ptr;
  logic [7:0]   pix [34*34];
  logic [271:0] b_rows [34];
  int           b_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ptr   <= 0;
      s_cache <= '0;
    end else if (s_req) begin
      s_cache <= s_rows[s_ptr % 8];
      s_ptr   <= s_ptr + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_ptr   <= 0;
      b_cache <= '0;
    end else if (b_req) begin
      b_cache <= (b_ptr < 34) ? b_rows[b_ptr] : '0;
      b_ptr   <= b_ptr + 1;
    end
  end

  // ---------------- monitor for the small instance ----------------
  int          s_pops  = 0;
  int          s_dones = 0;
  logic [1:0]  ob_r [$];
  logic [1:0]  ob_c [$];
  logic [71:0] ob_d [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready && s_en) begin
        ob_r.push_back(s_row);
        ob_c.push_back(s_col);
        ob_d.push_back(s_win);
      end
      if (s_req)  s_pops  = s_pops + 1;
      if (s_done) s_dones = s_dones + 1;
    end
  end

  // ---------------- reference windows ----------------
  function automatic logic [71:0] s_model(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], 8'(16 * (r + i) + (c + j))};
    return w;
  endfunction

  function automatic logic [71:0] b_model(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], pix[(r + i) * 34 + c + j]};
    return w;
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_start = 1'b0; s_en = 1'b1; s_empty = 1'b0; s_ready = 1'b1;
    b_start = 1'b0; b_en = 1'b1; b_empty = 1'b0; b_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic s_go();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic wait_win(input string tag, input int r, input int c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_valid === 1'b1 && s_row == 2'(r) && s_col == 2'(c)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_reach_window"}, 72'(ok), 72'd1);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (s_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_frame_done"}, 72'(ok), 72'd1);
    chk({tag, "_busy_at_done"}, 72'(s_busy), 72'd0);
    tick();
    tick();
  endtask

  task automatic check_seq(input string tag, input int obase, input int pbase, input int dbase);
    int er [4];
    int ec [4];
    er = '{0, 0, 1, 1};
    ec = '{0, 1, 0, 1};
    chk({tag, "_num_windows"}, 72'(ob_r.size() - obase), 72'd4);
    chk({tag, "_num_pops"}, 72'(s_pops - pbase), 72'd4);
    chk({tag, "_done_pulses"}, 72'(s_dones - dbase), 72'd1);
    for (int k = 0; k < 4; k++) begin
      if (obase + k < ob_r.size()) begin
        chk({tag, "_row"}, 72'(ob_r[obase + k]), 72'(er[k]));
        chk({tag, "_col"}, 72'(ob_c[obase + k]), 72'(ec[k]));
        chk({tag, "_data"}, ob_d[obase + k], s_model(er[k], ec[k]));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          obase, pbase, dbase, n, p;
    logic [71:0] saved;
    logic [31:0] v;
    logic [271:0] bv;
    int          er, ec, nwin;
    bit          seen;

    for (int r = 0; r < 8; r++) begin
      v = '0;
      for (int c = 0; c < 4; c++) v = {v[23:0], 8'(16 * r + c)};
      s_rows[r] = v;
    end
    for (int i = 0; i < 34 * 34; i++) pix[i] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 34; r++) begin
      bv = '0;
      for (int c = 0; c < 34; c++) bv = {bv[263:0], pix[r * 34 + c]};
      b_rows[r] = bv;
    end

    // Scenario 1: reset values, latency, nominal frame
    rst_n   = 1'b0;
    s_start = 1'b0; s_en = 1'b1; s_empty = 1'b0; s_ready = 1'b1;
    b_start = 1'b0; b_en = 1'b1; b_empty = 1'b0; b_ready = 1'b1;
    #1;
    chk("rst_req", 72'(s_req), 72'd0);
    chk("rst_valid", 72'(s_valid), 72'd0);
    chk("rst_busy", 72'(s_busy), 72'd0);
    chk("rst_done", 72'(s_done), 72'd0);
    chk("rst_data", s_win, 72'd0);
    chk("rst_rowcol", 72'({s_row, s_col}), 72'd0);
    chk("rst_state", 72'(s_state), 72'd0);
    do_reset();
    obase = ob_r.size(); pbase = s_pops; dbase = s_dones;
    s_go();
    n = 1;
    while (s_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("first_valid_cycle", 72'(n), 72'd7);
    chk("win00_const", s_win, 72'h000102101112202122);
    wait_done("nominal");
    check_seq("nominal", obase, pbase, dbase);
    if (obase + 3 < ob_d.size()) chk("win11_const", ob_d[obase + 3], 72'h111213212223313233);

    // Scenario 2: backpressure on window (0,1)
    do_reset();
    obase = ob_r.size(); pbase = s_pops; dbase = s_dones;
    s_go();
    wait_win("bp", 0, 1);
    s_ready = 1'b0;
    saved = s_win;
    p = s_pops;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", s_win, saved);
      chk("bp_col", 72'(s_col), 72'd1);
      chk("bp_valid", 72'(s_valid), 72'd1);
      chk("bp_no_pop", 72'(s_pops - p), 72'd0);
    end
    s_ready = 1'b1;
    wait_done("bp");
    check_seq("bp", obase, pbase, dbase);

    // Scenario 3: FIFO empty during SLIDE_REQ
    do_reset();
    obase = ob_r.size(); pbase = s_pops; dbase = s_dones;
    s_go();
    wait_win("empty", 0, 1);
    s_empty = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("empty_no_req", 72'(s_req), 72'd0);
      chk("empty_state", 72'(s_state), 72'd4);
      tick();
    end
    s_empty = 1'b0;
    #1;
    chk("empty_pop_on_drop", 72'(s_req), 72'd1);
    wait_done("empty");
    check_seq("empty", obase, pbase, dbase);

    // Scenario 4: clock enable low mid-STREAM
    do_reset();
    obase = ob_r.size(); pbase = s_pops; dbase = s_dones;
    s_go();
    wait_win("clken", 0, 1);
    s_en = 1'b0;
    saved = s_win;
    p = s_pops;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clken_valid", 72'(s_valid), 72'd1);
      chk("clken_col", 72'(s_col), 72'd1);
      chk("clken_data", s_win, saved);
      chk("clken_no_pop", 72'(s_pops - p), 72'd0);
    end
    s_en = 1'b1;
    wait_done("clken");
    check_seq("clken", obase, pbase, dbase);

    // Scenario 5: reset during window (1,0), then a clean frame
    do_reset();
    s_go();
    wait_win("abort", 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_req", 72'(s_req), 72'd0);
    chk("abort_valid", 72'(s_valid), 72'd0);
    chk("abort_busy", 72'(s_busy), 72'd0);
    chk("abort_done", 72'(s_done), 72'd0);
    chk("abort_data", s_win, 72'd0);
    chk("abort_rowcol", 72'({s_row, s_col}), 72'd0);
    chk("abort_state", 72'(s_state), 72'd0);
    tick();
    rst_n = 1'b1;
    tick();
    obase = ob_r.size(); pbase = s_pops; dbase = s_dones;
    s_go();
    wait_done("rerun");
    check_seq("rerun", obase, pbase, dbase);

    // Scenario 6: default parameters, random pixels and random win_ready
    do_reset();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    er = 0; ec = 0; nwin = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (b_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      b_ready = 1'($urandom_range(0, 1));
      if (b_valid === 1'b1 && b_ready) begin
        chk("big_row", 72'(b_row), 72'(er));
        chk("big_col", 72'(b_col), 72'(ec));
        chk("big_data", b_win, b_model(er, ec));
        nwin++;
        if (ec == 31) begin
          ec = 0;
          er++;
        end else begin
          ec++;
        end
      end
      tick();
    end
    chk("big_frame_done", 72'(seen), 72'd1);
    chk("big_busy_at_done", 72'(b_busy), 72'd0);
    tick();
    tick();
    chk("big_num_windows", 72'(nwin), 72'd1024);
    chk("big_num_pops", 72'(b_ptr), 72'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
